// File: rtl/k580vt57.sv
// k580vt57: 4-channel 8257-style DMA controller. It requests the bus with hrq/hlda and then
// runs fixed S1..S4 transfer cycles for the channel that wins arbitration.
module k580vt57 #(
  parameter int WAIT_STATES = 0,
  parameter bit AUTOLOAD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  iaddr,
  input  logic [7:0]  idata,
  output logic [7:0]  odata,
  input  logic        iwe_n,
  input  logic        ird_n,
  input  logic [3:0]  drq,
  output logic [3:0]  dack,
  output logic        hrq,
  input  logic        hlda,
  output logic [15:0] oaddr,
  output logic        aen,
  output logic        memr_n,
  output logic        memw_n,
  output logic        ior_n,
  output logic        iow_n,
  output logic        tc
);

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_S1, ST_S2, ST_S3, ST_S4} state_t;
  state_t r_state, w_state_next;

  logic [15:0] r_addr [4];
  logic [15:0] r_cnt  [4];
  logic [3:0]  r_en;
  logic        r_rot, r_tcstop, r_auto;
  logic [3:0]  r_tcf;
  logic        r_upd, r_ff;
  logic [1:0]  r_ch;
  logic [1:0]  r_wait;
  logic        r_we_d, r_rd_d;

  logic        w_we, w_rd, w_reg_acc, w_mode_sel, w_autoload;
  logic [15:0] w_cur_addr, w_cur_cnt;
  logic        w_tc_hit, w_xfer_end, w_done, w_reload, w_busy, w_strobe, w_latch, w_found;
  logic [3:0]  w_ch_oh, w_en_next, w_req, w_hit, w_wr_addr, w_wr_cnt;
  logic [1:0]  w_cand [4];
  logic [1:0]  w_win;
  logic [15:0] w_rd_reg;

  assign w_we       = iwe_n & ~r_we_d;
  assign w_rd       = ird_n & ~r_rd_d;
  assign w_reg_acc  = ~iaddr[3];
  assign w_mode_sel = (iaddr == 4'd8);
  assign w_autoload = AUTOLOAD_EN & r_auto;

  assign w_cur_addr = r_addr[r_ch];
  assign w_cur_cnt  = r_cnt[r_ch];
  assign w_tc_hit   = (w_cur_cnt[13:0] == 14'd0);
  assign w_xfer_end = (r_state == ST_S4);
  assign w_done     = w_xfer_end & w_tc_hit;
  assign w_reload   = w_done & w_autoload & (r_ch == 2'd2);
  assign w_ch_oh    = 4'b0001 << r_ch;

  // Burst re-arbitration at S4 must already see a channel that TC-stop is about to disable.
  assign w_en_next  = r_en & ~((w_done & r_tcstop) ? w_ch_oh : 4'b0000);
  assign w_req      = drq & (w_xfer_end ? w_en_next : r_en);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      // Rotating mode starts the search just after the last served channel.
      assign w_cand[gi]    = r_rot ? 2'(r_ch + 2'(gi + 1)) : 2'(gi);
      assign w_hit[gi]     = w_we & w_reg_acc &
                             ((iaddr[2:1] == 2'(gi)) | ((gi == 3) & w_autoload & (iaddr[2:1] == 2'd2)));
      assign w_wr_addr[gi] = w_hit[gi] & ~iaddr[0];
      assign w_wr_cnt[gi]  = w_hit[gi] & iaddr[0];
    end
  endgenerate

  always_comb begin
    w_win   = 2'd0;
    w_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && w_req[w_cand[i]]) begin
        w_win   = w_cand[i];
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE: if (|w_req) w_state_next = ST_REQ;
      ST_REQ: begin
        if (!(|w_req)) begin
          w_state_next = ST_IDLE;
        end else if (hlda) begin
          w_state_next = ST_S1;
          w_latch      = 1'b1;
        end
      end
      ST_S1: w_state_next = ST_S2;
      ST_S2: w_state_next = ST_S3;
      ST_S3: if (r_wait == 2'(WAIT_STATES)) w_state_next = ST_S4;
      ST_S4: begin
        if (hlda && (|w_req)) begin
          w_state_next = ST_S1;
          w_latch      = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ch    <= 2'd3;
      r_wait  <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) r_ch <= w_win;
      r_wait  <= (r_state == ST_S3) ? r_wait + 2'd1 : 2'd0;
    end
  end

  assign w_busy   = (r_state == ST_S1) | (r_state == ST_S2) | (r_state == ST_S3) | (r_state == ST_S4);
  assign w_strobe = (r_state == ST_S2) | (r_state == ST_S3);
  assign hrq      = (r_state != ST_IDLE);
  assign aen      = w_busy;
  assign dack     = w_busy ? w_ch_oh : 4'b0000;
  assign oaddr    = w_busy ? w_cur_addr : 16'h0000;
  assign memr_n   = ~(w_strobe & (w_cur_cnt[15:14] == 2'b10));
  assign iow_n    = ~(w_strobe & (w_cur_cnt[15:14] == 2'b10));
  assign memw_n   = ~(w_strobe & (w_cur_cnt[15:14] == 2'b01));
  assign ior_n    = ~(w_strobe & (w_cur_cnt[15:14] == 2'b01));
  assign tc       = (w_strobe | w_xfer_end) & w_tc_hit;

  assign w_rd_reg = iaddr[0] ? r_cnt[iaddr[2:1]] : r_addr[iaddr[2:1]];

  always_comb begin
    odata = 8'h00;
    if (w_reg_acc)       odata = r_ff ? w_rd_reg[15:8] : w_rd_reg[7:0];
    else if (w_mode_sel) odata = {3'b000, r_upd, r_tcf};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en     <= 4'd0;
      r_rot    <= 1'b0;
      r_tcstop <= 1'b0;
      r_auto   <= 1'b0;
      r_tcf    <= 4'd0;
      r_upd    <= 1'b0;
      r_ff     <= 1'b0;
      r_we_d   <= 1'b1;
      r_rd_d   <= 1'b1;
    end else begin
      r_we_d <= iwe_n;
      r_rd_d <= ird_n;
      r_upd  <= w_reload;
      if ((w_we | w_rd) & w_reg_acc) r_ff <= ~r_ff;
      if (w_we & w_mode_sel) begin
        r_en     <= idata[3:0];
        r_rot    <= idata[4];
        r_tcstop <= idata[6];
        r_auto   <= idata[7];
        r_ff     <= 1'b0;
      end else begin
        r_en <= w_en_next;
      end
      if (w_rd & w_mode_sel) r_tcf <= 4'd0;
      if (w_done) r_tcf[r_ch] <= 1'b1;
    end
  end

  // Address/count survive reset; a CPU write takes priority over the S4 update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_addr[i]) begin
          if (r_ff) r_addr[i][15:8] <= idata;
          else      r_addr[i][7:0]  <= idata;
        end else if (w_reload && i == 2) begin
          r_addr[i] <= r_addr[3];
        end else if (w_xfer_end && r_ch == 2'(i)) begin
          r_addr[i] <= r_addr[i] + 16'd1;
        end

        if (w_wr_cnt[i]) begin
          if (r_ff) r_cnt[i][15:8] <= idata;
          else      r_cnt[i][7:0]  <= idata;
        end else if (w_reload && i == 2) begin
          r_cnt[i] <= r_cnt[3];
        end else if (w_xfer_end && r_ch == 2'(i)) begin
          r_cnt[i] <= {r_cnt[i][15:14], r_cnt[i][13:0] - 14'd1};
        end
      end
    end
  end

endmodule

// File: tb/tb_k580vt57.sv
// Directed bench for k580vt57: register-access vector table plus hand-built DMA sequences.
module tb_k580vt57;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  iaddr;
  logic [7:0]  idata;
  logic [7:0]  odata;
  logic        iwe_n, ird_n;
  logic [3:0]  drq;
  logic [3:0]  dack;
  logic        hrq, hlda;
  logic [15:0] oaddr;
  logic        aen, memr_n, memw_n, ior_n, iow_n, tc;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       rd;
    logic [3:0] a;
    logic [7:0] d;
  } vec_t;
  vec_t vt [20];

  logic [7:0]  rv;
  logic [15:0] rv16;
  logic [24:0] got_v, exp_v;
  logic [15:0] seq;
  int          k, idx, ph, nx;
  logic        s, t, hr, fin;

  k580vt57 dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .odata(odata),
    .iwe_n(iwe_n), .ird_n(ird_n), .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda),
    .oaddr(oaddr), .aen(aen), .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n),
    .iow_n(iow_n), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    iaddr = a;
    idata = d;
    iwe_n = 1'b0;
    tick();
    iwe_n = 1'b1;
    tick();
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] v);
    iaddr = a;
    ird_n = 1'b0;
    tick();
    v = odata;
    ird_n = 1'b1;
    tick();
  endtask

  task automatic wr16(input logic [3:0] a, input logic [15:0] v);
    cpu_wr(a, v[7:0]);
    cpu_wr(a, v[15:8]);
  endtask

  task automatic rd16(input logic [3:0] a, output logic [15:0] v);
    logic [7:0] lo, hi;
    cpu_rd(a, lo);
    cpu_rd(a, hi);
    v = {hi, lo};
  endtask

  // Runs until the bus is released after at least one DMA cycle; returns aen-high cycle count.
  task automatic run_until_idle(input string name, input bit drop_on_tc, output int cnt);
    bit seen, done;
    seen = 1'b0;
    done = 1'b0;
    cnt  = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      if (aen) begin
        seen = 1'b1;
        cnt++;
      end
      if (drop_on_tc && tc) drq = 4'b0000;
      if (seen && !aen) done = 1'b1;
    end
    check({name, "_finished"}, 32'(done), 32'd1);
  endtask

  // Records dack at S1 of the first n transfers of a burst, then lets the burst end.
  task automatic burst_order(input string name, input logic [3:0] req, input int n, input logic [15:0] exp_seq);
    logic [15:0] got;
    int kk, xf;
    got  = 16'h0000;
    kk   = 0;
    xf   = 0;
    drq  = req;
    hlda = 1'b1;
    for (int c = 0; c < 200 && xf < n; c++) begin
      tick();
      if (aen) begin
        if (kk % 4 == 0) begin
          got[4*xf +: 4] = dack;
          xf++;
          if (xf == n) drq = 4'b0000;
        end
        kk++;
      end
    end
    for (int c = 0; c < 20 && aen; c++) tick();
    check(name, 32'(got), 32'(exp_seq));
    check({name, "_idle"}, {30'd0, aen, hrq}, 32'd0);
    hlda = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; iaddr = 4'd0; idata = 8'd0; iwe_n = 1'b1; ird_n = 1'b1;
    drq = 4'd0; hlda = 1'b0;

    vt[0]  = {1'b0, 4'h0, 8'h34};
    vt[1]  = {1'b0, 4'h0, 8'h12};
    vt[2]  = {1'b0, 4'h1, 8'h01};
    vt[3]  = {1'b0, 4'h1, 8'h40};
    vt[4]  = {1'b1, 4'h0, 8'h34};
    vt[5]  = {1'b1, 4'h0, 8'h12};
    vt[6]  = {1'b1, 4'h1, 8'h01};
    vt[7]  = {1'b1, 4'h1, 8'h40};
    vt[8]  = {1'b0, 4'h6, 8'hCD};
    vt[9]  = {1'b0, 4'h6, 8'hAB};
    vt[10] = {1'b1, 4'h6, 8'hCD};
    vt[11] = {1'b1, 4'h6, 8'hAB};
    vt[12] = {1'b0, 4'h2, 8'h55};
    vt[13] = {1'b0, 4'h8, 8'h00};
    vt[14] = {1'b0, 4'h2, 8'h66};
    vt[15] = {1'b0, 4'h2, 8'h77};
    vt[16] = {1'b1, 4'h2, 8'h66};
    vt[17] = {1'b1, 4'h2, 8'h77};
    vt[18] = {1'b1, 4'h8, 8'h00};
    vt[19] = {1'b1, 4'h9, 8'h00};

    tick(); tick(); tick();
    check("reset_outputs", {7'd0, hrq, aen, dack, tc, memr_n, memw_n, ior_n, iow_n, oaddr},
          {7'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'hF, 16'h0000});
    reset = 1'b0;
    iaddr = 4'd8;
    tick();
    check("reset_status", 32'(odata), 32'h0);

    for (int i = 0; i < 20; i++) begin
      if (vt[i].rd) begin
        cpu_rd(vt[i].a, rv);
        check($sformatf("vec%0d_rd_a%0d", i, vt[i].a), 32'(rv), 32'(vt[i].d));
      end else begin
        cpu_wr(vt[i].a, vt[i].d);
      end
    end

    // 80-transfer read-mode CRT fetch on ch2.
    wr16(4'd4, 16'h76D0);
    wr16(4'd5, 16'h804F);
    cpu_wr(4'd8, 8'h04);
    hlda = 1'b1;
    drq  = 4'b0100;
    tick();
    check("t1_req_phase", {30'd0, hrq, aen}, 32'b10);
    tick();
    check("t1_dack_latency", {12'd0, dack, oaddr}, {12'd0, 4'b0100, 16'h76D0});
    k = 0;
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (aen) begin
        idx = k / 4;
        ph  = k % 4;
        s = !(ph == 1 || ph == 2);
        t = (idx == 79) && (ph != 0);
        got_v = {oaddr, memr_n, iow_n, memw_n, ior_n, tc, dack};
        exp_v = {16'h76D0 + 16'(idx), s, s, 1'b1, 1'b1, t, 4'b0100};
        check($sformatf("t1_cycle%0d", k), 32'(got_v), 32'(exp_v));
        k++;
        if (tc) drq = 4'b0000;
        tick();
      end else begin
        fin = 1'b1;
      end
    end
    check("t1_aen_cycles", 32'(k), 32'd320);
    check("t1_hrq_released", 32'(hrq), 32'd0);
    hlda = 1'b0;
    rd16(4'd4, rv16);
    check("t1_ch2_addr_after", 32'(rv16), 32'h7720);
    rd16(4'd5, rv16);
    check("t1_ch2_count_after", 32'(rv16), 32'hBFFF);
    cpu_rd(4'd8, rv);
    check("t1_status", 32'(rv), 32'h04);
    cpu_rd(4'd8, rv);
    check("t1_status_cleared", 32'(rv), 32'h00);

    // Fixed vs rotating priority with ch0 and ch2 both requesting.
    wr16(4'd0, 16'h0000);
    wr16(4'd1, 16'h3FFF);
    wr16(4'd4, 16'h0000);
    wr16(4'd5, 16'h3FFF);
    cpu_wr(4'd8, 8'h05);
    burst_order("t2_fixed", 4'b0101, 4, 16'h1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    cpu_wr(4'd8, 8'h15);
    burst_order("t2_rotating", 4'b0101, 4, 16'h4141);

    // Autoload: ch2 reloads from ch3 on TC.
    cpu_wr(4'd8, 8'h84);
    wr16(4'd4, 16'h5000);
    wr16(4'd5, 16'h4000);
    wr16(4'd6, 16'h1234);
    iaddr = 4'd8;
    drq   = 4'b0100;
    hlda  = 1'b1;
    run_until_idle("t3", 1'b1, nx);
    check("t3_upd_pulse", 32'(odata), 32'h14);
    tick();
    check("t3_upd_cleared", 32'(odata), 32'h04);
    hlda = 1'b0;
    check("t3_xfer_cycles", 32'(nx), 32'd4);
    rd16(4'd4, rv16);
    check("t3_ch2_addr_reload", 32'(rv16), 32'h1234);
    rd16(4'd5, rv16);
    check("t3_ch2_count_reload", 32'(rv16), 32'h4000);
    cpu_rd(4'd8, rv);
    check("t3_status", 32'(rv), 32'h04);

    // TC-stop on ch0 after two transfers.
    wr16(4'd0, 16'h0100);
    wr16(4'd1, 16'h4001);
    cpu_wr(4'd8, 8'h41);
    drq  = 4'b0001;
    hlda = 1'b1;
    run_until_idle("t4", 1'b0, nx);
    check("t4_xfer_cycles", 32'(nx), 32'd8);
    hr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      hr = hr | hrq;
    end
    check("t4_no_hrq_after_stop", 32'(hr), 32'd0);
    drq  = 4'b0000;
    hlda = 1'b0;
    rd16(4'd0, rv16);
    check("t4_ch0_addr", 32'(rv16), 32'h0102);
    cpu_rd(4'd8, rv);
    check("t4_status", 32'(rv), 32'h01);

    // Reset in S2 aborts the cycle without touching ch1.
    wr16(4'd2, 16'h2000);
    wr16(4'd3, 16'h8005);
    cpu_wr(4'd8, 8'h02);
    drq  = 4'b0010;
    hlda = 1'b1;
    tick(); tick(); tick();
    check("t5_s2_strobes", {28'd0, memr_n, iow_n, dack[1], tc}, 32'b0010);
    reset = 1'b1;
    tick();
    check("t5_reset_abort", {23'd0, memr_n, iow_n, memw_n, ior_n, hrq, aen, dack},
          {23'd0, 4'hF, 1'b0, 1'b0, 4'd0});
    reset = 1'b0;
    drq   = 4'b0000;
    hlda  = 1'b0;
    tick();
    rd16(4'd2, rv16);
    check("t5_ch1_addr_kept", 32'(rv16), 32'h2000);
    rd16(4'd3, rv16);
    check("t5_ch1_count_kept", 32'(rv16), 32'h8005);

    // Request withdrawn before hlda, then address wrap on ch3.
    cpu_wr(4'd8, 8'h08);
    drq = 4'b1000;
    tick();
    check("t6_hrq_raised", {30'd0, hrq, aen}, 32'b10);
    drq = 4'b0000;
    tick();
    check("t6_withdrawn", {26'd0, hrq, aen, dack}, 32'd0);
    wr16(4'd6, 16'hFFFF);
    wr16(4'd7, 16'h4000);
    drq  = 4'b1000;
    hlda = 1'b1;
    run_until_idle("t6", 1'b1, nx);
    hlda = 1'b0;
    check("t6_xfer_cycles", 32'(nx), 32'd4);
    rd16(4'd6, rv16);
    check("t6_addr_wrap", 32'(rv16), 32'h0000);
    rd16(4'd7, rv16);
    check("t6_count_wrap", 32'(rv16), 32'h7FFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
